// File: rtl/qerv_dbus_lsu_if.sv
// Wishbone-classic data-bus bundle between the load/store unit (master)
// and the memory side (slave).
interface qerv_dbus_lsu_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        ack;
  logic [31:0] rdt;

  modport master (
    output adr, dat, sel, we, cyc,
    input  ack, rdt
  );

  modport slave (
    input  adr, dat, sel, we, cyc,
    output ack, rdt
  );
endinterface

// File: rtl/qerv_dbus_lsu.sv
// Bit-serial load/store unit: gathers store data W bits per beat, runs one
// Wishbone-classic cycle, then aligns/extends load data and streams it back.
module qerv_dbus_lsu #(
  parameter int W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_we,
  input  logic [1:0]       i_size,
  input  logic             i_signed,
  input  logic [1:0]       i_lsb,
  input  logic [31:0]      i_adr,
  input  logic             i_en,
  input  logic [W-1:0]     i_rs2,
  output logic [W-1:0]     o_rd,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_trap,
  qerv_dbus_lsu_if.master  dbus
);

  localparam int BEATS = 32 / W;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, BUS, RETURN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          we_reg, we_next;
  logic [1:0]    size_reg, size_next;
  logic          signed_reg, signed_next;
  logic [1:0]    lsb_reg, lsb_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          done_reg, done_next;
  logic          trap_reg, trap_next;
  logic [31:0]   adr_reg, adr_next;
  logic [31:0]   dat_reg, dat_next;
  logic [3:0]    sel_reg, sel_next;
  logic          bus_we_reg, bus_we_next;
  logic          cyc_reg, cyc_next;

  logic [31:0]   wdata_shift;
  logic [31:0]   store_word;
  logic [31:0]   aligned;
  logic [31:0]   load_word;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lsb);
    if (size[1])      return 4'b1111;
    else if (size[0]) return lsb[1] ? 4'b1100 : 4'b0011;
    else              return 4'b0001 << lsb;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    if (size[1])      return lsb != 2'b00;
    else if (size[0]) return lsb[0];
    else              return 1'b0;
  endfunction

  // The last collected beat is folded in before formatting, so the bus data
  // is ready in the same edge that enters BUS.
  assign wdata_shift = {i_rs2, wdata_reg[31:W]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_word[8*gi +: 8] = size_reg[1] ? wdata_shift[8*gi +: 8] :
                                     size_reg[0] ? wdata_shift[8*(gi%2) +: 8] :
                                                   wdata_shift[7:0];
    end
  endgenerate

  assign aligned   = dbus.rdt >> {lsb_reg, 3'b000};
  assign load_word = size_reg[1] ? aligned :
                     size_reg[0] ? {{16{signed_reg & aligned[15]}}, aligned[15:0]} :
                                   {{24{signed_reg & aligned[7]}},  aligned[7:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      size_reg   <= 2'b00;
      signed_reg <= 1'b0;
      lsb_reg    <= 2'b00;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      done_reg   <= 1'b0;
      trap_reg   <= 1'b0;
      adr_reg    <= '0;
      dat_reg    <= '0;
      sel_reg    <= '0;
      bus_we_reg <= 1'b0;
      cyc_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      we_reg     <= we_next;
      size_reg   <= size_next;
      signed_reg <= signed_next;
      lsb_reg    <= lsb_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      done_reg   <= done_next;
      trap_reg   <= trap_next;
      adr_reg    <= adr_next;
      dat_reg    <= dat_next;
      sel_reg    <= sel_next;
      bus_we_reg <= bus_we_next;
      cyc_reg    <= cyc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    we_next     = we_reg;
    size_next   = size_reg;
    signed_next = signed_reg;
    lsb_next    = lsb_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    done_next   = 1'b0;
    trap_next   = 1'b0;
    adr_next    = adr_reg;
    dat_next    = dat_reg;
    sel_next    = sel_reg;
    bus_we_next = bus_we_reg;
    cyc_next    = cyc_reg;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          we_next     = i_we;
          size_next   = i_size;
          signed_next = i_signed;
          lsb_next    = i_lsb;
          cnt_next    = '0;
          if (misaligned(i_size, i_lsb)) begin
            trap_next = 1'b1;
          end else if (i_we) begin
            state_next = COLLECT;
          end else begin
            state_next  = BUS;
            adr_next    = i_adr;
            cyc_next    = 1'b1;
            bus_we_next = 1'b0;
            sel_next    = lane_sel(i_size, i_lsb);
          end
        end
      end
      COLLECT: begin
        if (i_en) begin
          wdata_next = wdata_shift;
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_next  = BUS;
            cnt_next    = '0;
            adr_next    = i_adr;
            cyc_next    = 1'b1;
            bus_we_next = 1'b1;
            sel_next    = lane_sel(size_reg, lsb_reg);
            dat_next    = store_word;
          end
        end
      end
      BUS: begin
        // Address and data stay parked after the cycle; only strobes drop.
        if (dbus.ack) begin
          cyc_next    = 1'b0;
          bus_we_next = 1'b0;
          sel_next    = 4'b0000;
          cnt_next    = '0;
          if (we_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = RETURN;
            rdata_next = load_word;
          end
        end
      end
      RETURN: begin
        if (i_en) begin
          rdata_next = {{W{1'b0}}, rdata_reg[31:W]};
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_rd     = (state_reg == RETURN && i_en) ? rdata_reg[W-1:0] : '0;
  assign o_busy   = (state_reg != IDLE);
  assign o_done   = done_reg;
  assign o_trap   = trap_reg;
  assign dbus.adr = adr_reg;
  assign dbus.dat = dat_reg;
  assign dbus.sel = sel_reg;
  assign dbus.we  = bus_we_reg;
  assign dbus.cyc = cyc_reg;

endmodule

// File: tb/tb_qerv_dbus_lsu.sv
// Directed bench for qerv_dbus_lsu: one W=1 and one W=4 instance, exercised
// one at a time through a shared set of tasks.
module tb_qerv_dbus_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, start4;
  logic        we, sgn, en;
  logic [1:0]  size, lsb;
  logic [31:0] adr;
  logic        rs2_1;
  logic [3:0]  rs2_4;
  logic        rd1;
  logic [3:0]  rd4;
  logic        busy1, busy4, done1, done4, trap1, trap4;

  qerv_dbus_lsu_if bus1();
  qerv_dbus_lsu_if bus4();

  qerv_dbus_lsu #(.W(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_lsb(lsb), .i_adr(adr), .i_en(en), .i_rs2(rs2_1),
    .o_rd(rd1), .o_busy(busy1), .o_done(done1), .o_trap(trap1), .dbus(bus1)
  );

  qerv_dbus_lsu #(.W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_lsb(lsb), .i_adr(adr), .i_en(en), .i_rs2(rs2_4),
    .o_rd(rd4), .o_busy(busy4), .o_done(done4), .o_trap(trap4), .dbus(bus4)
  );

  bit use4;
  int w;
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] c_rd, c_adr, c_dat;
  logic [3:0]  c_sel;
  logic        c_we, c_cyc, c_busy, c_done, c_trap;

  always_comb begin
    if (use4) begin
      c_rd = {28'b0, rd4}; c_adr = bus4.adr; c_dat = bus4.dat; c_sel = bus4.sel;
      c_we = bus4.we; c_cyc = bus4.cyc; c_busy = busy4; c_done = done4; c_trap = trap4;
    end else begin
      c_rd = {31'b0, rd1}; c_adr = bus1.adr; c_dat = bus1.dat; c_sel = bus1.sel;
      c_we = bus1.we; c_cyc = bus1.cyc; c_busy = busy1; c_done = done1; c_trap = trap1;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pick(input bit four);
    use4 = four;
    w    = four ? 4 : 1;
    #1;
  endtask

  task automatic set_ack(input bit a);
    bus1.ack = a & !use4;
    bus4.ack = a & use4;
  endtask

  task automatic start_op(input bit iwe, input logic [1:0] isz, input bit isg,
                          input logic [1:0] ilsb, input logic [31:0] iadr);
    we = iwe; size = isz; sgn = isg; lsb = ilsb; adr = iadr;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] isz, input bit isg,
                         input logic [1:0] ilsb, input logic [31:0] iadr,
                         input logic [31:0] rdt, input int waits, input bit stall,
                         input logic [3:0] exp_sel, input logic [31:0] exp_val);
    int beats, n, guard;
    logic [31:0] got;
    n = 32 / w;
    start_op(1'b0, isz, isg, ilsb, iadr);
    check_vec({tag, ".cyc"}, c_cyc, 1);
    check_vec({tag, ".we"}, c_we, 0);
    check_vec({tag, ".sel"}, c_sel, exp_sel);
    check_vec({tag, ".adr"}, c_adr, iadr);
    check_vec({tag, ".busy"}, c_busy, 1);
    repeat (waits) tick();
    bus1.rdt = rdt; bus4.rdt = rdt;
    set_ack(1'b1);
    tick();
    set_ack(1'b0);
    bus1.rdt = '1; bus4.rdt = '1;
    check_vec({tag, ".cyc_drop"}, c_cyc, 0);
    check_vec({tag, ".sel_drop"}, c_sel, 0);
    beats = 0; got = '0; guard = 0;
    while (beats < n && guard < 400) begin
      en = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (en) begin
        got = got | (c_rd << (beats * w));
        beats++;
      end else begin
        check_vec({tag, ".rd_idle"}, c_rd, 0);
      end
      tick();
      guard++;
    end
    en = 1'b0;
    check_vec({tag, ".beats"}, beats, n);
    check_vec({tag, ".data"}, got, exp_val);
    check_vec({tag, ".done"}, c_done, 1);
    tick();
    check_vec({tag, ".done_end"}, c_done, 0);
    check_vec({tag, ".busy_end"}, c_busy, 0);
    $display("load  %s W=%0d adr=%h -> %h", tag, w, iadr, got);
  endtask

  task automatic do_store(input string tag, input logic [1:0] isz, input logic [1:0] ilsb,
                          input logic [31:0] iadr, input logic [31:0] data, input bit stall,
                          input logic [3:0] exp_sel, input logic [31:0] exp_dat);
    int beats, n, guard;
    logic [31:0] d;
    n = 32 / w;
    start_op(1'b1, isz, 1'b0, ilsb, iadr);
    check_vec({tag, ".cyc_collect"}, c_cyc, 0);
    check_vec({tag, ".busy"}, c_busy, 1);
    d = data; beats = 0; guard = 0;
    while (beats < n && guard < 400) begin
      en = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rs2_1 = d[0];
      rs2_4 = d[3:0];
      tick();
      if (en) begin
        d = d >> w;
        beats++;
      end
      guard++;
    end
    en = 1'b0;
    check_vec({tag, ".beats"}, beats, n);
    check_vec({tag, ".cyc"}, c_cyc, 1);
    check_vec({tag, ".we"}, c_we, 1);
    check_vec({tag, ".sel"}, c_sel, exp_sel);
    check_vec({tag, ".dat"}, c_dat, exp_dat);
    check_vec({tag, ".adr"}, c_adr, iadr);
    set_ack(1'b1);
    tick();
    set_ack(1'b0);
    check_vec({tag, ".done"}, c_done, 1);
    check_vec({tag, ".cyc_drop"}, c_cyc, 0);
    check_vec({tag, ".we_drop"}, c_we, 0);
    tick();
    check_vec({tag, ".done_end"}, c_done, 0);
    check_vec({tag, ".busy_end"}, c_busy, 0);
    check_vec({tag, ".dat_held"}, c_dat, exp_dat);
    $display("store %s W=%0d adr=%h dat=%h sel=%b", tag, w, iadr, c_dat, c_sel);
  endtask

  task automatic trap_case(input string tag, input logic [1:0] isz, input logic [1:0] ilsb);
    start_op(1'b0, isz, 1'b0, ilsb, 32'h0000_0300);
    check_vec({tag, ".trap"}, c_trap, 1);
    check_vec({tag, ".busy"}, c_busy, 0);
    check_vec({tag, ".cyc"}, c_cyc, 0);
    tick();
    check_vec({tag, ".trap_end"}, c_trap, 0);
    check_vec({tag, ".cyc_end"}, c_cyc, 0);
    check_vec({tag, ".busy_end"}, c_busy, 0);
    $display("trap  %s W=%0d size=%b lsb=%b", tag, w, isz, ilsb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; we = 1'b0; sgn = 1'b0; en = 1'b0;
    size = 2'b00; lsb = 2'b00; adr = '0; rs2_1 = 1'b0; rs2_4 = '0;
    bus1.ack = 1'b0; bus4.ack = 1'b0; bus1.rdt = '0; bus4.rdt = '0;
    pick(1'b0);
    tick(); tick();

    for (int k = 0; k < 2; k++) begin
      pick(k[0]);
      check_vec("rst.cyc", c_cyc, 0);
      check_vec("rst.sel", c_sel, 0);
      check_vec("rst.adr", c_adr, 0);
      check_vec("rst.dat", c_dat, 0);
      check_vec("rst.busy", c_busy, 0);
      check_vec("rst.done", c_done, 0);
      check_vec("rst.trap", c_trap, 0);
    end
    rst = 1'b0;
    tick();

    pick(1'b0);
    do_load("w1_word", 2'b10, 1'b0, 2'd0, 32'h0000_0100, 32'h8765_4321, 2, 1'b0, 4'b1111, 32'h8765_4321);

    pick(1'b1);
    do_load("w4_sbyte", 2'b00, 1'b1, 2'd3, 32'h0000_0204, 32'h8012_3456, 1, 1'b0, 4'b1000, 32'hFFFF_FF80);
    do_load("w4_ubyte", 2'b00, 1'b0, 2'd3, 32'h0000_0204, 32'h8012_3456, 0, 1'b0, 4'b1000, 32'h0000_0080);
    do_load("w4_uhalf", 2'b01, 1'b0, 2'd0, 32'h0000_0208, 32'h1234_F00D, 0, 1'b0, 4'b0011, 32'h0000_F00D);
    do_store("w4_half", 2'b01, 2'd2, 32'h0000_0400, 32'h1234_ABCD, 1'b0, 4'b1100, 32'hABCD_ABCD);
    do_store("w4_byte", 2'b00, 2'd1, 32'h0000_0404, 32'h0000_00A5, 1'b0, 4'b0010, 32'hA5A5_A5A5);

    trap_case("w4_word_lsb1", 2'b10, 2'd1);
    pick(1'b0);
    trap_case("w1_half_lsb3", 2'b01, 2'd3);

    do_store("w1_word_stall", 2'b10, 2'd0, 32'h0000_0500, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    do_load("w1_shalf_stall", 2'b01, 1'b1, 2'd2, 32'h0000_0508, 32'h9ABC_1234, 1, 1'b1, 4'b1100, 32'hFFFF_9ABC);

    // Reset in the middle of a bus cycle, then a late ack that must be ignored.
    start_op(1'b0, 2'b10, 1'b0, 2'd0, 32'h0000_0600);
    check_vec("rstbus.cyc_before", c_cyc, 1);
    tick();
    rst = 1'b1;
    #1;
    check_vec("rstbus.cyc", c_cyc, 0);
    check_vec("rstbus.sel", c_sel, 0);
    check_vec("rstbus.we", c_we, 0);
    check_vec("rstbus.busy", c_busy, 0);
    check_vec("rstbus.adr", c_adr, 0);
    tick();
    rst = 1'b0;
    bus1.rdt = 32'h5555_5555;
    set_ack(1'b1);
    tick();
    set_ack(1'b0);
    check_vec("rstbus.late_ack_busy", c_busy, 0);
    check_vec("rstbus.late_ack_cyc", c_cyc, 0);
    check_vec("rstbus.late_ack_done", c_done, 0);
    $display("reset mid-bus W=%0d", w);
    tick();
    do_load("w1_after_rst", 2'b10, 1'b0, 2'd0, 32'h0000_0700, 32'h0BAD_F00D, 0, 1'b0, 4'b1111, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
